// File: rtl/fpga_bus_pkg.sv
// Shared types and constants for the FPGA memory-link bus scheduler.
package fpga_bus_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BEAT_W = 64;

    localparam logic [WORD_W-1:0] DEFAULT_IDLE_WORD = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WRESP,
        RDATA,
        DONE
    } sched_state_e;

endpackage

// File: rtl/fpga_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester always wins, a tie goes to
// the port that was not granted last.
module fpga_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       idx
);

    // Port that wins the next tie.
    logic prio_q;
    logic prio_d;

    always_comb begin
        case (req)
            2'b01:   idx = 1'b0;
            2'b10:   idx = 1'b1;
            default: idx = prio_q;
        endcase

        gnt = '0;
        if (req != 2'b00) begin
            gnt = idx ? 2'b10 : 2'b01;
        end

        prio_d = prio_q;
        if (advance && (req != 2'b00)) begin
            prio_d = ~idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/fpga_bus_scheduler.sv
// Shares the 32-bit multiplexed controller<->memory link between the I-cache
// (port 0) and D-cache (port 1), one line burst at a time.
module fpga_bus_scheduler
    import fpga_bus_pkg::*;
#(
    parameter int unsigned       BURST_BEATS = 4,
    parameter logic [WORD_W-1:0] IDLE_WORD   = DEFAULT_IDLE_WORD
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [1:0][WORD_W-1:0] req_addr,
    input  logic [1:0]             req_read,
    input  logic [1:0]             req_write,
    input  logic [1:0][BEAT_W-1:0] req_wdata,
    output logic [1:0]             req_ready,
    output logic [WORD_W-1:0]      req_raddr,
    output logic [BEAT_W-1:0]      req_rdata,
    output logic [1:0]             req_rvalid,

    input  logic [WORD_W-1:0]      address_data_bus_m_to_c,
    input  logic                   address_on_m_to_c,
    input  logic                   data_on_m_to_c,
    input  logic                   read_en_m_to_c,
    input  logic                   write_en_m_to_c,
    input  logic                   resp_m_to_c,

    output logic [WORD_W-1:0]      address_data_bus_c_to_m,
    output logic                   address_on_c_to_m,
    output logic                   data_on_c_to_m,
    output logic                   read_en_c_to_m,
    output logic                   write_en_c_to_m,
    output logic                   resp_c_to_m
);

    localparam int unsigned       WORDS     = 2 * BURST_BEATS;
    localparam int unsigned       CNT_W     = $clog2(WORDS);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS - 1);

    sched_state_e state_q, state_d;
    logic                 g_q, g_d;
    logic                 is_write_q, is_write_d;
    logic [WORD_W-1:0]    addr_q, addr_d;
    logic [BEAT_W-1:0]    wbuf_q, wbuf_d;
    logic [WORD_W-1:0]    rbuf_lo_q, rbuf_lo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [1:0]           req_ready_q, req_ready_d;
    logic [WORD_W-1:0]    req_raddr_q, req_raddr_d;
    logic [BEAT_W-1:0]    req_rdata_q, req_rdata_d;
    logic [1:0]           req_rvalid_q, req_rvalid_d;
    logic [WORD_W-1:0]    bus_q, bus_d;
    logic                 addr_on_q, addr_on_d;
    logic                 data_on_q, data_on_d;
    logic                 rd_en_q, rd_en_d;
    logic                 wr_en_q, wr_en_d;
    logic                 resp_q, resp_d;

    logic [1:0]           arb_req;
    logic                 arb_advance;
    logic [1:0]           arb_gnt;
    logic                 arb_idx;
    logic                 unused_inputs;

    always_comb begin
        arb_req       = req_read | req_write;
        arb_advance   = (state_q == IDLE) && (arb_req != 2'b00);
        unused_inputs = &{address_on_m_to_c, read_en_m_to_c, write_en_m_to_c};
    end

    fpga_rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (arb_advance),
        .gnt     (arb_gnt),
        .idx     (arb_idx)
    );

    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        is_write_d   = is_write_q;
        addr_d       = addr_q;
        wbuf_d       = wbuf_q;
        rbuf_lo_d    = rbuf_lo_q;
        cnt_d        = cnt_q;
        req_ready_d  = '0;
        req_rvalid_d = '0;
        req_raddr_d  = req_raddr_q;
        req_rdata_d  = req_rdata_q;

        case (state_q)
            IDLE: begin
                if (arb_req != 2'b00) begin
                    g_d         = arb_idx;
                    addr_d      = req_addr[arb_idx];
                    is_write_d  = req_write[arb_idx] & ~req_read[arb_idx];
                    if (is_write_d) begin
                        wbuf_d = req_wdata[arb_idx];
                    end
                    req_ready_d = arb_gnt;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                cnt_d   = '0;
                state_d = is_write_q ? WDATA : RDATA;
            end
            WDATA: begin
                if (cnt_q == LAST_WORD) begin
                    state_d = WRESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // High word just went out: fetch the next beat for the following pair.
                    if (cnt_q[0]) begin
                        wbuf_d           = req_wdata[g_q];
                        req_ready_d[g_q] = 1'b1;
                    end
                end
            end
            WRESP: begin
                if (resp_m_to_c) begin
                    state_d = DONE;
                end
            end
            RDATA: begin
                if (data_on_m_to_c) begin
                    if (!cnt_q[0]) begin
                        rbuf_lo_d = address_data_bus_m_to_c;
                    end else begin
                        req_rvalid_d[g_q] = 1'b1;
                        req_rdata_d       = {address_data_bus_m_to_c, rbuf_lo_q};
                        req_raddr_d       = addr_q;
                    end
                    if (cnt_q == LAST_WORD) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus qualifiers are decoded from the next state so they register in step with it.
        bus_d     = IDLE_WORD;
        addr_on_d = 1'b0;
        data_on_d = 1'b0;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        resp_d    = 1'b0;
        case (state_d)
            ADDR: begin
                bus_d     = addr_d;
                addr_on_d = 1'b1;
                rd_en_d   = ~is_write_d;
                wr_en_d   = is_write_d;
            end
            WDATA: begin
                bus_d     = cnt_d[0] ? wbuf_d[BEAT_W-1:WORD_W] : wbuf_d[WORD_W-1:0];
                data_on_d = 1'b1;
                wr_en_d   = 1'b1;
            end
            DONE: begin
                resp_d = 1'b1;
            end
            default: begin
                bus_d = IDLE_WORD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            g_q          <= 1'b0;
            is_write_q   <= 1'b0;
            addr_q       <= '0;
            wbuf_q       <= '0;
            rbuf_lo_q    <= '0;
            cnt_q        <= '0;
            req_ready_q  <= '0;
            req_raddr_q  <= '0;
            req_rdata_q  <= '0;
            req_rvalid_q <= '0;
            bus_q        <= IDLE_WORD;
            addr_on_q    <= 1'b0;
            data_on_q    <= 1'b0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            resp_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            is_write_q   <= is_write_d;
            addr_q       <= addr_d;
            wbuf_q       <= wbuf_d;
            rbuf_lo_q    <= rbuf_lo_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            req_raddr_q  <= req_raddr_d;
            req_rdata_q  <= req_rdata_d;
            req_rvalid_q <= req_rvalid_d;
            bus_q        <= bus_d;
            addr_on_q    <= addr_on_d;
            data_on_q    <= data_on_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            resp_q       <= resp_d;
        end
    end

    assign req_ready               = req_ready_q;
    assign req_raddr               = req_raddr_q;
    assign req_rdata               = req_rdata_q;
    assign req_rvalid              = req_rvalid_q;
    assign address_data_bus_c_to_m = bus_q;
    assign address_on_c_to_m       = addr_on_q;
    assign data_on_c_to_m          = data_on_q;
    assign read_en_c_to_m          = rd_en_q;
    assign write_en_c_to_m         = wr_en_q;
    assign resp_c_to_m             = resp_q;

endmodule
